// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding, default array sizes and the flush-length
// helper for the systolic_matmul_nxn engine and its systolic_pe cells.
package systolic_pkg;

  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 32;
  localparam int K_MAX_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Last value of the flush counter: the final beat needs 2N-1 extra cycles
  // to reach PE(N-1,N-1) through the skew stage, lane delay and array hops.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary MAC cell. Registers a to the right and
// b downward, and accumulates a*b every cycle (wrapping modulo 2^AW).
// clr zeroes the accumulator synchronously at the start of a job.
// Optional macro SYSTOLIC_SIGNED_EN: treat operands as two's complement and
// sign-extend products; default build is unsigned with zero-extension.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0] a_ext, b_ext, prod;
  logic [AW-1:0]   prod_ext;

  // Full-width product, extended to the accumulator width, and next state
  always_comb begin
`ifdef SYSTOLIC_SIGNED_EN
    a_ext    = {{DW{a_in[DW-1]}}, a_in};
    b_ext    = {{DW{b_in[DW-1]}}, b_in};
    prod     = a_ext * b_ext;
    prod_ext = AW'($signed(prod));
`else
    a_ext    = {{DW{1'b0}}, a_in};
    b_ext    = {{DW{1'b0}}, b_in};
    prod     = a_ext * b_ext;
    prod_ext = AW'(prod);
`endif
    a_d   = a_in;
    b_d   = b_in;
    acc_d = clr ? '0 : acc_q + prod_ext;
  end

  // Pass-through operand registers and the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// systolic_matmul_nxn: N x N output-stationary systolic matrix multiply with
// run-time reduction length, internal input skew, valid/ready beat stream and
// a start/done control FSM. C(i,j) appears at c_flat[(i*N+j)*AW +: AW].
// Optional macro SYSTOLIC_SIGNED_EN (in systolic_pe): signed operands.
module systolic_matmul_nxn
  import systolic_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int K_MAX = K_MAX_DEF,
  localparam int KW    = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_vec,
  input  logic [N*DW-1:0]   b_vec,
  output logic              busy,
  output logic              done,
  output logic              c_valid,
  output logic [N*N*AW-1:0] c_flat
);

  localparam int            FW         = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_len(N));

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          c_valid_q, c_valid_d;
  logic          clr;
  logic          accept;

  assign accept = in_valid && (state_q == STREAM);

  // Next-state, job bookkeeping and status outputs
  always_comb begin
    state_d   = state_q;
    k_len_d   = k_len_q;
    beat_d    = beat_q;
    flush_d   = flush_q;
    c_valid_d = c_valid_q;
    clr       = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr     = 1'b1;
          k_len_d = k_len;
          beat_d  = '0;
          flush_d = '0;
          if (k_len == '0) begin
            state_d   = DONE;
            c_valid_d = 1'b1;
          end else begin
            state_d   = STREAM;
            c_valid_d = 1'b0;
          end
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == k_len_q - 1'b1) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == FLUSH_LAST) begin
          state_d   = DONE;
          c_valid_d = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_len_q   <= '0;
      beat_q    <= '0;
      flush_q   <= '0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_len_q   <= k_len_d;
      beat_q    <= beat_d;
      flush_q   <= flush_d;
      c_valid_q <= c_valid_d;
    end
  end

  assign c_valid = c_valid_q;

  logic [DW-1:0] a_skew [N];
  logic [DW-1:0] b_skew [N];

  for (genvar l = 0; l < N; l++) begin : g_skew
    logic [DW-1:0] a_sk_q [0:l];
    logic [DW-1:0] a_sk_d [0:l];
    logic [DW-1:0] b_sk_q [0:l];
    logic [DW-1:0] b_sk_d [0:l];

    // Stage 0 captures the accepted beat (zeros on bubbles); stages 1..l add the lane skew
    always_comb begin
      a_sk_d[0] = accept ? a_vec[l*DW +: DW] : '0;
      b_sk_d[0] = accept ? b_vec[l*DW +: DW] : '0;
      for (int s = 1; s <= l; s++) begin
        a_sk_d[s] = a_sk_q[s-1];
        b_sk_d[s] = b_sk_q[s-1];
      end
    end

    // Skew shift registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= l; s++) begin
          a_sk_q[s] <= '0;
          b_sk_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s <= l; s++) begin
          a_sk_q[s] <= a_sk_d[s];
          b_sk_q[s] <= b_sk_d[s];
        end
      end
    end

    assign a_skew[l] = a_sk_q[l];
    assign b_skew[l] = b_sk_q[l];
  end

  logic [DW-1:0] pe_a_in  [N][N];
  logic [DW-1:0] pe_b_in  [N][N];
  logic [DW-1:0] pe_a_out [N][N];
  logic [DW-1:0] pe_b_out [N][N];
  logic [AW-1:0] pe_acc   [N][N];
  logic [N-1:0]  unused_a_edge;
  logic [N-1:0]  unused_b_edge;

  for (genvar r = 0; r < N; r++) begin : g_row
    assign unused_a_edge[r] = ^pe_a_out[r][N-1];
    assign unused_b_edge[r] = ^pe_b_out[N-1][r];
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign pe_a_in[r][c] = a_skew[r];
      end else begin : g_a_chain
        assign pe_a_in[r][c] = pe_a_out[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign pe_b_in[r][c] = b_skew[c];
      end else begin : g_b_chain
        assign pe_b_in[r][c] = pe_b_out[r-1][c];
      end

      systolic_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .a_in (pe_a_in[r][c]),
        .b_in (pe_b_in[r][c]),
        .a_out(pe_a_out[r][c]),
        .b_out(pe_b_out[r][c]),
        .acc  (pe_acc[r][c])
      );

      assign c_flat[(r*N+c)*AW +: AW] = pe_acc[r][c];
    end
  end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// tb_systolic_matmul_nxn: directed self-checking bench for systolic_matmul_nxn.
// Main instance is N=4, DW=8, AW=32; a second AW=16 instance covers wraparound.
`timescale 1ns/1ps
module tb_systolic_matmul_nxn;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int K_MAX = 255;
  localparam int KW    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   a_vec;
  logic [N*DW-1:0]   b_vec;
  logic              busy;
  logic              done;
  logic              c_valid;
  logic [N*N*AW-1:0] c_flat;

  systolic_matmul_nxn #(.N(N), .DW(DW), .AW(AW), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .busy(busy), .done(done), .c_valid(c_valid), .c_flat(c_flat)
  );

  logic              o_start;
  logic [KW-1:0]     o_k_len;
  logic              o_in_valid;
  logic              o_in_ready;
  logic [N*DW-1:0]   o_a_vec;
  logic [N*DW-1:0]   o_b_vec;
  logic              o_busy;
  logic              o_done;
  logic              o_c_valid;
  logic [N*N*16-1:0] o_c_flat;

  systolic_matmul_nxn #(.N(N), .DW(DW), .AW(16), .K_MAX(K_MAX)) dut_ovf (
    .clk(clk), .rst(rst), .start(o_start), .k_len(o_k_len),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .a_vec(o_a_vec), .b_vec(o_b_vec),
    .busy(o_busy), .done(o_done), .c_valid(o_c_valid), .c_flat(o_c_flat)
  );

  int exp_basic [16] = '{70, 80, 90, 100, 96, 110, 124, 138,
                         122, 140, 158, 176, 148, 170, 192, 214};

  // mode 0: A(i,k)=i+k+1 ; mode 1: all 8'hFF
  function automatic logic [N*DW-1:0] beat_a(input int mode, input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = (mode == 0) ? DW'(i + k + 1) : 8'hFF;
    return v;
  endfunction

  // mode 0: B(k,j)=j+k+5 ; mode 1: all 2
  function automatic logic [N*DW-1:0] beat_b(input int mode, input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = (mode == 0) ? DW'(j + k + 5) : 8'd2;
    return v;
  endfunction

  // Drives one job on the main instance and reports the observed timing
  task automatic run_job(input int klen, input int mode, input bit bubbles, input bit poke_flush,
                         output bit ready_next, output int first_acc, output int last_acc,
                         output int done_edge);
    int  k, guard, phase;
    bit  acc_now;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(klen);
    @(posedge clk); #1;
    start = 1'b0;
    ready_next = in_ready;
    k = 0; guard = 0; phase = 0;
    first_acc = -1; last_acc = -1; done_edge = -1;
    while (k < klen && guard < 200) begin
      in_valid = bubbles ? (phase % 2 == 0) : 1'b1;
      a_vec    = beat_a(mode, k);
      b_vec    = beat_b(mode, k);
      acc_now  = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        k++;
      end
      phase++;
      guard++;
    end
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    if (poke_flush) begin
      start = 1'b1;
      k_len = 8'd1;
    end
    for (int g = 0; g < 60; g++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        done_edge = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_vec = '0; b_vec = '0;
    o_start = 1'b0; o_k_len = '0; o_in_valid = 1'b0; o_a_vec = '0; o_b_vec = '0;
    #22;
    compared++;
    if ({in_ready, busy, done, c_valid} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got ready/busy/done/cvalid=%b expected 0000",
               {in_ready, busy, done, c_valid});
    end
    compared++;
    if (c_flat !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_cflat: got %h expected 0", c_flat);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ready_next; int fa, la, de;
    logic [AW-1:0] got;
    run_job(4, 0, 1'b0, 1'b0, ready_next, fa, la, de);
    compared++;
    if (ready_next !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_ready_after_start: got %b expected 1", ready_next);
    end
    compared++;
    if (la - fa !== 3) begin
      mismatched++;
      $display("[TB] FAIL basic_throughput: got span %0d expected 3", la - fa);
    end
    compared++;
    if (de < 0 || de - la !== 8) begin
      mismatched++;
      $display("[TB] FAIL basic_latency: got done_edge %0d last_accept %0d expected +8", de, la);
    end
    compared++;
    if (c_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_cvalid: got %b expected 1", c_valid);
    end
    for (int i = 0; i < 16; i++) begin
      got = c_flat[i*AW +: AW];
      compared++;
      if (got !== AW'(exp_basic[i])) begin
        mismatched++;
        $display("[TB] FAIL basic_c(%0d,%0d): got %0d expected %0d", i / 4, i % 4, got, exp_basic[i]);
      end
    end
    @(posedge clk); #1;
    compared++;
    if ({done, busy, c_valid} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL basic_after_done: got done/busy/cvalid=%b expected 001", {done, busy, c_valid});
    end
  endtask

  task automatic test_bubbles();
    bit ready_next; int fa, la, de;
    logic [AW-1:0] got;
    run_job(4, 0, 1'b1, 1'b0, ready_next, fa, la, de);
    compared++;
    if (la - fa !== 6) begin
      mismatched++;
      $display("[TB] FAIL bubbles_spacing: got span %0d expected 6", la - fa);
    end
    compared++;
    if (de < 0 || de - la !== 8) begin
      mismatched++;
      $display("[TB] FAIL bubbles_latency: got done_edge %0d last_accept %0d expected +8", de, la);
    end
    for (int i = 0; i < 16; i++) begin
      got = c_flat[i*AW +: AW];
      compared++;
      if (got !== AW'(exp_basic[i])) begin
        mismatched++;
        $display("[TB] FAIL bubbles_c(%0d,%0d): got %0d expected %0d", i / 4, i % 4, got, exp_basic[i]);
      end
    end
  endtask

  task automatic test_signed();
    bit ready_next; int fa, la, de;
    logic [AW-1:0] got, expv;
`ifdef SYSTOLIC_SIGNED_EN
    expv = 32'hFFFF_FFFA;
`else
    expv = 32'd1530;
`endif
    run_job(3, 1, 1'b0, 1'b0, ready_next, fa, la, de);
    compared++;
    if (de < 0 || de - la !== 8) begin
      mismatched++;
      $display("[TB] FAIL signed_latency: got done_edge %0d last_accept %0d expected +8", de, la);
    end
    for (int i = 0; i < 16; i++) begin
      got = c_flat[i*AW +: AW];
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("[TB] FAIL signed_c(%0d,%0d): got %h expected %h", i / 4, i % 4, got, expv);
      end
    end
  endtask

  task automatic test_overflow();
    int k, guard;
    bit acc_now, seen;
    logic [15:0] got, expv;
`ifdef SYSTOLIC_SIGNED_EN
    expv = 16'd2;
`else
    expv = 16'd64514;
`endif
    @(posedge clk); #1;
    o_start = 1'b1;
    o_k_len = 8'd2;
    @(posedge clk); #1;
    o_start = 1'b0;
    k = 0; guard = 0;
    while (k < 2 && guard < 50) begin
      o_in_valid = 1'b1;
      o_a_vec    = {N{8'hFF}};
      o_b_vec    = {N{8'hFF}};
      acc_now    = o_in_ready;
      @(posedge clk); #1;
      if (acc_now) k++;
      guard++;
    end
    o_in_valid = 1'b0;
    seen = 1'b0;
    for (int g = 0; g < 60; g++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL overflow_done: got no done pulse expected one");
    end
    for (int i = 0; i < 16; i++) begin
      got = o_c_flat[i*16 +: 16];
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("[TB] FAIL overflow_c(%0d,%0d): got %0d expected %0d", i / 4, i % 4, got, expv);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int accepted, guard;
    bit acc_now;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    accepted = 0; guard = 0;
    while (accepted < 2 && guard < 20) begin
      in_valid = 1'b1;
      a_vec    = beat_a(0, accepted);
      b_vec    = beat_b(0, accepted);
      acc_now  = in_ready;
      @(posedge clk); #1;
      if (acc_now) accepted++;
      guard++;
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midjob_busy_before_rst: got %b expected 1", busy);
    end
    rst = 1'b1;
    #2;
    compared++;
    if ({busy, in_ready, c_valid, done} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL midjob_status: got busy/ready/cvalid/done=%b expected 0000",
               {busy, in_ready, c_valid, done});
    end
    compared++;
    if (c_flat !== '0) begin
      mismatched++;
      $display("[TB] FAIL midjob_cflat: got %h expected 0", c_flat);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_k_zero();
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if ({done, c_valid, in_ready} !== 3'b110) begin
      mismatched++;
      $display("[TB] FAIL kzero_status: got done/cvalid/ready=%b expected 110", {done, c_valid, in_ready});
    end
    compared++;
    if (c_flat !== '0) begin
      mismatched++;
      $display("[TB] FAIL kzero_cflat: got %h expected 0", c_flat);
    end
    @(posedge clk); #1;
    compared++;
    if ({done, busy} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL kzero_after: got done/busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_start_in_flush();
    bit ready_next; int fa, la, de;
    logic [AW-1:0] got;
    run_job(4, 0, 1'b0, 1'b1, ready_next, fa, la, de);
    compared++;
    if (de < 0 || de - la !== 8) begin
      mismatched++;
      $display("[TB] FAIL flushstart_latency: got done_edge %0d last_accept %0d expected +8", de, la);
    end
    for (int i = 0; i < 16; i++) begin
      got = c_flat[i*AW +: AW];
      compared++;
      if (got !== AW'(exp_basic[i])) begin
        mismatched++;
        $display("[TB] FAIL flushstart_c(%0d,%0d): got %0d expected %0d", i / 4, i % 4, got, exp_basic[i]);
      end
    end
    @(posedge clk); #1;
    compared++;
    if ({busy, in_ready, c_valid} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL flushstart_idle: got busy/ready/cvalid=%b expected 001", {busy, in_ready, c_valid});
    end
  endtask

  initial begin
    $display("[TB] starting systolic_matmul_nxn bench");
    test_reset();
    test_basic();
    test_bubbles();
    test_signed();
    test_overflow();
    test_reset_mid_job();
    test_basic();
    test_k_zero();
    test_basic();
    test_start_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_nxn.md
# systolic_matmul_nxn

Parametrised N×N output-stationary systolic matrix-multiply engine, next generation of the fixed 4×4 array. It computes C = A·B for an N×K by K×N product, with K chosen at run time up to K_MAX. Input skewing is internal, the stream uses a valid/ready handshake with bubble tolerance, and a start/done control FSM drives it. It sits behind the GPU tile loader, which streams one A column and one B row per accepted beat.

## Interface
- N, 4, array dimension (rows = columns), ≥2
- DW, 8, operand width
- AW, 32, accumulator/result width, ≥2·DW
- K_MAX, 255, maximum reduction length; KW = $clog2(K_MAX+1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a job (sampled only in IDLE)
- k_len  in  KW  reduction length, sampled with start
- in_valid  in  1  a_vec/b_vec beat valid
- in_ready  out  1  engine accepts beat
- a_vec  in  N·DW  A column k; lane i = A(i,k)
- b_vec  in  N·DW  B row k; lane j = B(k,j)
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- c_valid  out  1  c_flat holds a complete result
- c_flat  out  N·N·AW  C(i,j) at index (i·N+j)·AW

## Operation
- Reset: state IDLE; in_ready, busy, done, c_valid = 0; all accumulators and skew/pipe registers = 0.
- FSM states:
  - IDLE: start → clear accumulators, drop c_valid, latch k_len. If k_len=0, go to DONE; otherwise go to STREAM.
  - STREAM: in_ready=1. A beat is accepted when in_valid&&in_ready. Accepting beat k_len−1 moves to FLUSH.
  - FLUSH: counts 2N−1 cycles, then moves to DONE.
  - DONE: done=1, c_valid←1, then IDLE.
- busy = 1 in STREAM, FLUSH and DONE.
- Skew: lane i of A and lane j of B are delayed by i and j registers respectively. Cycles without an accepted beat inject zeros into all lanes, so bubbles never corrupt results.
- PE(i,j): registers its a rightward and its b downward; acc += a·b each cycle.
- Arithmetic: products are full 2·DW bits, zero-extended to AW. Accumulation wraps modulo 2^AW with no saturation.
- start outside IDLE is ignored. in_valid outside STREAM is ignored.
- c_flat holds its value until the next accepted start.
- rst at any point, including mid-STREAM or mid-FLUSH, aborts the job and restores the reset values.

## Timing
- Throughput: one beat per cycle when in_valid is held high.
- Latency: if the last beat is accepted at edge L, then done and c_valid rise at edge L+2N (edge L+8 for N=4).
- k_len=0: done pulses in the cycle after start, with c_flat all zero.
- Start-to-first-accept: in_ready rises the cycle after start is sampled.

## Configuration
- SYSTOLIC_SIGNED_EN defined: operands are two's complement and products are sign-extended to AW.
- SYSTOLIC_SIGNED_EN undefined: operands are unsigned and products are zero-extended.

## Structure
- Package systolic_pkg holds:
  - the state enum {IDLE, STREAM, FLUSH, DONE};
  - default N/DW/AW constants;
  - the flush-length function 2N−1.
- Sub-module systolic_pe holds one MAC cell: a/b pass-through registers plus an accumulator with a synchronous clear. It is generated N×N times in the top level.
- Skew registers and the FSM live in systolic_matmul_nxn.

## Test plan
- Basic product: N=4, k_len=4, back-to-back beats with A(i,k)=i+k+1 and B(k,j)=j+k+5 (i, j, k from 0) → done at L+8. C rows must be 70 80 90 100 / 96 110 124 138 / 122 140 158 176 / 148 170 192 214.
- Bubbles: same data with in_valid low on alternate cycles → identical C; done at last accept +8.
- Overflow: AW=16, k_len=2, all operands 255 → every C = 64514 (130050 mod 65536).
- Signed mode: with SYSTOLIC_SIGNED_EN, k_len=3, all a=8'hFF and all b=2 → every C = 32'hFFFFFFFA. Without the macro, the same stimulus → 1530.
- Reset mid-job: assert rst after 2 accepted beats → busy, in_ready and c_valid are 0 and c_flat is 0. A subsequent full run reproduces the Basic product result.
- Control edges:
  - k_len=0 → done the cycle after start, C all 0.
  - start asserted during FLUSH → ignored, and the result is unchanged.
